// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, credit-limited memory requests,
// in-order response queue to decode, redirect with stale-response drop. Option macro: IF_MISALIGN_EXC_EN.
module if_fetch_unit #(
    parameter int                ADDR_W    = 64,
    parameter int                INST_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(64'h8000_0000),
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] pc_rom,
    input  logic              rom_ready_i,
    input  logic              rsp_valid_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] if_pc,
    output logic              misalign_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [PW-1:0]     head_reg, tail_reg;
    logic [CW-1:0]     count_reg;
    logic [OW-1:0]     outst_reg, drop_reg, drop_next;
    logic [TW-1:0]     tag_wr_reg, tag_rd_reg;
    logic [CW:0]       inflight;

    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];
    logic [ADDR_W-1:0] tag_pc [MAX_OUTST];

    logic              req_fire, rsp_keep, push, pop, halt, mis_push;
    logic [ADDR_W-1:0] target_pc, push_pc;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTST - 1)) ? '0 : p + TW'(1);
    endfunction

`ifdef IF_MISALIGN_EXC_EN
    logic halt_reg, mis_pend_reg, mis_target;
    logic q_mis [DEPTH];

    assign target_pc  = redirect_pc_i;
    assign mis_target = |redirect_pc_i[1:0];
    assign halt       = halt_reg;
    // The pseudo-entry waits until every pre-redirect request has been answered (and dropped).
    assign mis_push   = mis_pend_reg && (outst_reg == '0) && !redirect_i;
    assign misalign_o = inst_valid_o && q_mis[head_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_reg     <= 1'b0;
            mis_pend_reg <= 1'b0;
        end else if (redirect_i) begin
            halt_reg     <= mis_target;
            mis_pend_reg <= mis_target;
        end else if (mis_push) begin
            mis_pend_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mis[tail_reg] <= mis_push;
    end
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc_i[1:0];
    assign target_pc     = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign halt          = 1'b0;
    assign mis_push      = 1'b0;
    assign misalign_o    = 1'b0;
`endif

    // Credits: a request is issued only if its response is guaranteed a queue slot.
    assign inflight     = (CW+1)'(count_reg) + (CW+1)'(outst_reg);
    assign rom_ce       = !rst && !redirect_i && !halt && (outst_reg < OW'(MAX_OUTST))
                          && (inflight < (CW+1)'(DEPTH));
    assign pc_rom       = pc_reg;
    assign req_fire     = rom_ce && rom_ready_i;
    assign rsp_keep     = rsp_valid_i && !redirect_i && (state_reg == RUN);
    assign push         = rsp_keep || mis_push;
    assign push_pc      = mis_push ? pc_reg : tag_pc[tag_rd_reg];
    assign inst_valid_o = !rst && (count_reg != '0) && !redirect_i;
    assign pop          = inst_valid_o && inst_ready_i;
    assign inst_o       = q_inst[head_reg];
    assign if_pc        = q_pc[head_reg];

    always_comb begin
        drop_next = drop_reg;
        if (redirect_i)
            drop_next = outst_reg - OW'(rsp_valid_i);
        else if (rsp_valid_i && (drop_reg != '0))
            drop_next = drop_reg - OW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= RUN;
            pc_reg     <= RESET_PC;
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            outst_reg  <= '0;
            drop_reg   <= '0;
            tag_wr_reg <= '0;
            tag_rd_reg <= '0;
        end else begin
            outst_reg <= outst_reg + OW'(req_fire) - OW'(rsp_valid_i);
            drop_reg  <= drop_next;
            state_reg <= (drop_next != '0) ? DRAIN : RUN;
            // Tags follow every request/response, including ones dropped after a redirect.
            if (req_fire)    tag_wr_reg <= tag_inc(tag_wr_reg);
            if (rsp_valid_i) tag_rd_reg <= tag_inc(tag_rd_reg);
            if (redirect_i) begin
                pc_reg    <= target_pc;
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (req_fire) pc_reg   <= pc_reg + ADDR_W'(4);
                if (push)     tail_reg <= tail_reg + PW'(1);
                if (pop)      head_reg <= head_reg + PW'(1);
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) tag_pc[tag_wr_reg] <= pc_reg;
        if (push) begin
            q_pc[tail_reg]   <= push_pc;
            q_inst[tail_reg] <= mis_push ? '0 : inst_i;
        end
    end

    ap_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        rsp_valid_i |-> (outst_reg != '0));
    ap_credit: assert property (@(posedge clk) disable iff (rst)
        (inflight <= (CW+1)'(DEPTH)) && (outst_reg <= OW'(MAX_OUTST)));
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: 64-bit instance with a queue-based memory model,
// plus a 32-bit instance reset at 0xFFFF_FFFC to observe PC wrap.
module tb_if_fetch_unit;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [31:0] KEY    = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        redirect, rom_ce, rom_ready, rsp_valid, inst_valid, inst_ready, misalign;
    logic [63:0] redirect_pc, pc_rom, if_pc;
    logic [31:0] inst_in, inst_out;
    logic        rsp_en;

    if_fetch_unit u_dut (
        .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .rom_ce(rom_ce), .pc_rom(pc_rom), .rom_ready_i(rom_ready),
        .rsp_valid_i(rsp_valid), .inst_i(inst_in), .inst_valid_o(inst_valid),
        .inst_ready_i(inst_ready), .inst_o(inst_out), .if_pc(if_pc), .misalign_o(misalign)
    );

    // Wrap instance: always-ready 1-cycle memory and decode
    logic        w_rom_ce, w_rsp_valid, w_inst_valid, w_mis;
    logic [31:0] w_pc_rom, w_inst, w_inst_o, w_if_pc;

    if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .rom_ce(w_rom_ce), .pc_rom(w_pc_rom), .rom_ready_i(1'b1),
        .rsp_valid_i(w_rsp_valid), .inst_i(w_inst), .inst_valid_o(w_inst_valid),
        .inst_ready_i(1'b1), .inst_o(w_inst_o), .if_pc(w_if_pc), .misalign_o(w_mis)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) w_rsp_valid <= 1'b0;
        else begin
            w_rsp_valid <= w_rom_ce;
            w_inst      <= w_pc_rom ^ KEY;
        end
    end

    // In-order memory model: answers the oldest request the cycle after it, when rsp_en
    logic [63:0] mq[$];
    logic        mq_ne = 1'b0;
    logic [63:0] mq_head = 64'd0;
    int          n_req = 0;

    assign rsp_valid = mq_ne && rsp_en;
    assign inst_in   = mq_head[31:0] ^ KEY;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mq_ne <= 1'b0;
        end else begin
            if (rsp_valid) void'(mq.pop_front());
            if (rom_ce && rom_ready) begin
                mq.push_back(pc_rom);
                n_req <= n_req + 1;
            end
            mq_ne <= (mq.size() != 0);
            if (mq.size() != 0) mq_head <= mq[0];
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Delivery scoreboard: expected PC stream restarts on reset and on each redirect
    logic [63:0] exp_pc = RST_PC;
    logic        exp_mis = 1'b0;
    int          n_deliv = 0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            exp_pc  = RST_PC;
            exp_mis = 1'b0;
        end else if (redirect) begin
`ifdef IF_MISALIGN_EXC_EN
            exp_pc  = redirect_pc;
            exp_mis = (redirect_pc[1:0] != 2'b00);
`else
            exp_pc  = {redirect_pc[63:2], 2'b00};
            exp_mis = 1'b0;
`endif
        end else if (inst_valid && inst_ready) begin
            $display("deliver pc=%h inst=%h misalign=%0d", if_pc, inst_out, misalign);
            check_val("deliv_pc", if_pc, exp_pc);
            check_val("deliv_inst", 64'(inst_out), exp_mis ? 64'd0 : 64'(exp_pc[31:0] ^ KEY));
            check_val("deliv_misalign", 64'(misalign), 64'(exp_mis));
            exp_pc = exp_pc + 64'd4;
            n_deliv++;
        end
    end

    int          d0;
    logic [63:0] exp_stall;

    initial begin
        redirect = 1'b0; redirect_pc = 64'd0; rom_ready = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1;

        // T1 reset: outputs quiet while rst high
        repeat (2) @(negedge clk);
        #2;
        check_val("rst_rom_ce", 64'(rom_ce), 64'd0);
        check_val("rst_inst_valid", 64'(inst_valid), 64'd0);
        check_val("rst_misalign", 64'(misalign), 64'd0);
        check_val("rst_wrap_rom_ce", 64'(w_rom_ce), 64'd0);

        @(negedge clk); rst = 1'b0; #2;
        check_val("t1_rom_ce", 64'(rom_ce), 64'd1);
        check_val("t1_first_pc", pc_rom, RST_PC);
        check_val("t1_valid_c0", 64'(inst_valid), 64'd0);
        check_val("t5_first_pc", 64'(w_pc_rom), 64'hFFFF_FFFC);
        @(negedge clk); #2;
        check_val("t1_valid_c1", 64'(inst_valid), 64'd0);
        check_val("t1_second_pc", pc_rom, RST_PC + 64'd4);
        check_val("t5_wrap_pc", 64'(w_pc_rom), 64'd0);
        @(negedge clk); #2;
        check_val("t1_valid_c2", 64'(inst_valid), 64'd1);
        check_val("t5_valid", 64'(w_inst_valid), 64'd1);
        check_val("t5_if_pc0", 64'(w_if_pc), 64'hFFFF_FFFC);
        check_val("t5_inst0", 64'(w_inst_o), 64'(32'hFFFF_FFFC ^ KEY));
        @(negedge clk); #2;
        check_val("t5_if_pc1", 64'(w_if_pc), 64'd0);

        // Sustained throughput: one delivery per cycle
        d0 = n_deliv;
        repeat (8) @(negedge clk);
        #2;
        check_val("t1_throughput", 64'(n_deliv - d0), 64'd8);

        // T2 decode backpressure for 10 cycles
        @(negedge clk); inst_ready = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        check_val("t2_rom_ce_off", 64'(rom_ce), 64'd0);
        check_val("t2_valid_held", 64'(inst_valid), 64'd1);
        check_val("t2_queued", 64'(n_req - n_deliv - mq.size()), 64'd4);
        @(negedge clk); inst_ready = 1'b1;
        repeat (10) @(negedge clk);

        // T4 memory stall for 5 cycles
        @(negedge clk); rom_ready = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        exp_stall = RST_PC + 64'(4 * n_req);
        check_val("t4_ce_held", 64'(rom_ce), 64'd1);
        check_val("t4_pc_held", pc_rom, exp_stall);
        @(negedge clk); rom_ready = 1'b1; #2;
        check_val("t4_pc_at_accept", pc_rom, exp_stall);
        @(negedge clk); #2;
        check_val("t4_pc_single_inc", pc_rom, exp_stall + 64'd4);
        repeat (4) @(negedge clk);

        // T3 redirect with two requests in flight
        @(negedge clk); rsp_en = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_val("t3_inflight", 64'(mq.size()), 64'd2);
        check_val("t3_ce_capped", 64'(rom_ce), 64'd0);
        @(negedge clk); redirect = 1'b1; redirect_pc = 64'h8000_0100; #2;
        check_val("t3_redir_ce", 64'(rom_ce), 64'd0);
        check_val("t3_redir_valid", 64'(inst_valid), 64'd0);
        d0 = n_deliv;
        @(negedge clk); redirect = 1'b0; rsp_en = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        check_val("t3_resume_count", 64'(n_deliv - d0), 64'd8);

        // T6 misaligned redirect target
        @(negedge clk); redirect = 1'b1; redirect_pc = 64'h8000_0102;
        @(negedge clk); redirect = 1'b0; #2;
`ifdef IF_MISALIGN_EXC_EN
        check_val("t6_no_req", 64'(rom_ce), 64'd0);
        for (int i = 0; i < 20 && !inst_valid; i++) begin
            @(negedge clk); #2;
        end
        check_val("t6_exc_seen", 64'(inst_valid), 64'd1);
        check_val("t6_exc_flag", 64'(misalign), 64'd1);
        @(negedge clk); #2;
        check_val("t6_halt_ce", 64'(rom_ce), 64'd0);
        check_val("t6_halt_valid", 64'(inst_valid), 64'd0);
        @(negedge clk); redirect = 1'b1; redirect_pc = 64'h8000_0200;
        @(negedge clk); redirect = 1'b0; d0 = n_deliv;
`else
        check_val("t6_aligned_ce", 64'(rom_ce), 64'd1);
        check_val("t6_aligned_pc", pc_rom, 64'h8000_0100);
        d0 = n_deliv;
`endif
        repeat (5) @(negedge clk);
        #2;
        check_val("t6_resume_count", 64'(n_deliv - d0), 64'd4);
        repeat (3) @(negedge clk);

        // Reset asserted mid-stream
        @(negedge clk); rst = 1'b1; #2;
        check_val("midrst_rom_ce", 64'(rom_ce), 64'd0);
        check_val("midrst_valid", 64'(inst_valid), 64'd0);
        @(negedge clk); rst = 1'b0; #2;
        check_val("midrst_pc", pc_rom, RST_PC);
        check_val("midrst_ce", 64'(rom_ce), 64'd1);
        repeat (6) @(negedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
